// File: rtl/fxp8s_pe_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : fxp8s_pe_seq                                               |
// | Description : Upstream sequencer for one fxp8s processing element.       |
// |               Takes a byte stream of 3 row operands followed by col_len  |
// |               column operands. It clears the PE, loads the row buffer,   |
// |               and streams the columns for multiply-accumulate. It then   |
// |               waits DRAIN_CYC cycles for the PE pipeline to empty, reads |
// |               the accumulator and returns it on a valid/ready port.      |
// |               All data is 8-bit two's complement, 4.3 fixed point.       |
// | Ports       : clk, rst                   clock / sync active-high reset  |
// |               start, col_len, busy       job control                     |
// |               s_data, s_valid, s_ready   operand stream in               |
// |               pe_rstn, pe_in_row, pe_en_in, pe_in_data,                  |
// |               pe_en_out, pe_out_data     PE control / data               |
// |               res_data, res_valid, res_ready  result out                 |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module fxp8s_pe_seq #(
   parameter int CW        = 4,
   parameter int DRAIN_CYC = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [CW-1:0] col_len,
   output logic          busy,
   input  logic [7:0]    s_data,
   input  logic          s_valid,
   output logic          s_ready,
   output logic          pe_rstn,
   output logic          pe_in_row,
   output logic          pe_en_in,
   output logic [7:0]    pe_in_data,
   output logic          pe_en_out,
   input  logic [7:0]    pe_out_data,
   output logic [7:0]    res_data,
   output logic          res_valid,
   input  logic          res_ready
);

   localparam int              c_DW         = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
   localparam logic [c_DW-1:0] c_DRAIN_LAST = c_DW'(DRAIN_CYC - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_CLR    = 3'd1,
      S_LOAD   = 3'd2,
      S_STREAM = 3'd3,
      S_DRAIN  = 3'd4,
      S_READ   = 3'd5,
      S_RESULT = 3'd6
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [CW-1:0]   r_col_len;
   logic [1:0]      r_load_cnt;
   logic [CW-1:0]   r_col_cnt;
   logic [c_DW-1:0] r_drain_cnt;
   logic            r_pe_en_in;
   logic            r_pe_in_row;
   logic [7:0]      r_pe_in_data;
   logic [7:0]      r_res_data;
   logic            w_s_ready;
   logic            w_beat;

   // Next-state and state-decoded outputs.
   always_comb begin
      w_state_nxt = r_state;
      w_s_ready   = 1'b0;
      busy        = 1'b1;
      pe_en_out   = 1'b0;
      res_valid   = 1'b0;
      case (r_state)
         S_IDLE: begin
            busy = 1'b0;
            if (start) w_state_nxt = S_CLR;
         end
         S_CLR: w_state_nxt = S_LOAD;
         S_LOAD: begin
            w_s_ready = 1'b1;
            if (s_valid && r_load_cnt == 2'd2)
               w_state_nxt = (r_col_len == '0) ? S_DRAIN : S_STREAM;
         end
         S_STREAM: begin
            w_s_ready = 1'b1;
            if (s_valid && r_col_cnt == r_col_len - CW'(1))
               w_state_nxt = S_DRAIN;
         end
         // DRAIN is entered right after the last beat is accepted, so its
         // first cycle is the one in which that beat is presented to the PE.
         S_DRAIN: if (r_drain_cnt == c_DRAIN_LAST) w_state_nxt = S_READ;
         S_READ: begin
            pe_en_out   = 1'b1;
            w_state_nxt = S_RESULT;
         end
         S_RESULT: begin
            res_valid = 1'b1;
            if (res_ready) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign w_beat  = s_valid & w_s_ready;
   assign s_ready = w_s_ready;
   // The PE is held in clear during reset as well as for the CLR cycle.
   assign pe_rstn = ~(rst | (r_state == S_CLR));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_col_len    <= '0;
         r_load_cnt   <= '0;
         r_col_cnt    <= '0;
         r_drain_cnt  <= '0;
         r_pe_en_in   <= 1'b0;
         r_pe_in_row  <= 1'b0;
         r_pe_in_data <= '0;
         r_res_data   <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_pe_en_in  <= w_beat;
         r_pe_in_row <= w_beat && (r_state == S_LOAD);
         if (w_beat) r_pe_in_data <= s_data;
         case (r_state)
            S_IDLE:   if (start) r_col_len <= col_len;
            S_CLR: begin
               r_load_cnt  <= '0;
               r_col_cnt   <= '0;
               r_drain_cnt <= '0;
            end
            S_LOAD:   if (w_beat) r_load_cnt <= r_load_cnt + 2'd1;
            S_STREAM: if (w_beat) r_col_cnt <= r_col_cnt + CW'(1);
            S_DRAIN:  r_drain_cnt <= r_drain_cnt + c_DW'(1);
            S_READ:   r_res_data <= pe_out_data;
            default:  ;
         endcase
      end
   end

   assign pe_en_in   = r_pe_en_in;
   assign pe_in_row  = r_pe_in_row;
   assign pe_in_data = r_pe_in_data;
   assign res_data   = r_res_data;

endmodule
`default_nettype wire

// File: tb/tb_fxp8s_pe_seq.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module      : tb_fxp8s_pe_seq                                            |
// | Description : Self-checking bench for fxp8s_pe_seq with a behavioural    |
// |               PE stand-in and an arithmetic reference for the result.    |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_fxp8s_pe_seq;
   localparam int CW        = 4;
   localparam int DRAIN_CYC = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [CW-1:0] col_len;
   logic          busy;
   logic [7:0]    s_data;
   logic          s_valid;
   logic          s_ready;
   logic          pe_rstn;
   logic          pe_in_row;
   logic          pe_en_in;
   logic [7:0]    pe_in_data;
   logic          pe_en_out;
   logic [7:0]    pe_out_data;
   logic [7:0]    res_data;
   logic          res_valid;
   logic          res_ready;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   fxp8s_pe_seq #(.CW(CW), .DRAIN_CYC(DRAIN_CYC)) dut (
      .clk(clk), .rst(rst), .start(start), .col_len(col_len), .busy(busy),
      .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
      .pe_rstn(pe_rstn), .pe_in_row(pe_in_row), .pe_en_in(pe_en_in),
      .pe_in_data(pe_in_data), .pe_en_out(pe_en_out), .pe_out_data(pe_out_data),
      .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- behavioural PE: row[0] * column, 2-cycle latency -----
   logic signed [7:0]  pe_row0;
   int                 pe_rc;
   logic               pe_pv;
   logic signed [15:0] pe_prod;
   logic [7:0]         pe_acc;

   always @(posedge clk) begin
      if (!pe_rstn) begin
         pe_row0 <= '0; pe_rc <= 0; pe_pv <= 1'b0; pe_prod <= '0; pe_acc <= '0;
      end else begin
         pe_pv <= 1'b0;
         if (pe_en_in) begin
            if (pe_in_row) begin
               if (pe_rc == 0) pe_row0 <= pe_in_data;
               pe_rc <= pe_rc + 1;
            end else begin
               pe_pv   <= 1'b1;
               pe_prod <= pe_row0 * $signed(pe_in_data);
            end
         end
         if (pe_pv) pe_acc <= pe_acc + 8'(pe_prod >>> 3);
      end
   end
   // Garbage outside en_out so a mistimed read is visible.
   assign pe_out_data = pe_en_out ? pe_acc : 8'hA5;

   // Every beat the PE receives, as {in_row, data}.
   logic [8:0] cap_q[$];
   always @(posedge clk) if (!rst && pe_en_in) cap_q.push_back({pe_in_row, pe_in_data});

   // ---------------- job description and reference -----------------------
   byte row_a[3];
   byte col_a[16];
   int  n_cols;

   function automatic logic [7:0] ref_result();
      int s = 0;
      for (int i = 0; i < n_cols; i++) s += (int'(row_a[0]) * int'(col_a[i])) >>> 3;
      return 8'(s);
   endfunction

   task automatic do_job(input int stall_mode, input int rr_delay,
                         input bit chk_lat, input bit poke_start);
      int idx, total, cyc0, lat, guard;
      bit acc_now;
      logic [7:0] exp_res;
      logic [8:0] exp_q[$];
      exp_res = ref_result();
      for (int i = 0; i < 3; i++) exp_q.push_back({1'b1, row_a[i]});
      for (int i = 0; i < n_cols; i++) exp_q.push_back({1'b0, col_a[i]});
      cap_q.delete();
      res_ready = (rr_delay == 0);
      start = 1'b1; col_len = CW'(n_cols);
      @(posedge clk); #1;
      start = 1'b0; cyc0 = cyc;
      total = 3 + n_cols; idx = 0; guard = 0;
      while (idx < total && guard < 400) begin
         case (stall_mode)
            0:       s_valid = 1'b1;
            1:       s_valid = (guard % 2 == 1);
            default: s_valid = ($urandom_range(0, 3) != 0);
         endcase
         s_data = (idx < 3) ? row_a[idx] : col_a[idx-3];
         if (poke_start && (guard == 2 || guard == 4)) begin
            start = 1'b1; col_len = CW'(n_cols + 5);
         end else start = 1'b0;
         acc_now = s_valid && s_ready;
         @(posedge clk); #1;
         if (acc_now) idx++;
         guard++;
      end
      s_valid = 1'b0; start = 1'b0;
      checks++;
      if (idx != total) begin
         errors++; $display("FAIL feed_timeout: accepted %0d beats, required %0d", idx, total);
      end
      guard = 0;
      while (!res_valid && guard < 200) begin @(posedge clk); #1; guard++; end
      lat = cyc - cyc0;
      checks++;
      if (res_valid !== 1'b1) begin
         errors++; $display("FAIL res_valid_timeout: res_valid=%b, required 1", res_valid);
      end
      if (chk_lat) begin
         checks++;
         if (lat != 9 + n_cols) begin
            errors++; $display("FAIL latency: %0d cycles, required %0d", lat, 9 + n_cols);
         end
      end
      checks++;
      if (res_data !== exp_res) begin
         errors++; $display("FAIL result: res_data=%h, required %h", res_data, exp_res);
      end
      for (int k = 0; k < rr_delay; k++) begin
         @(posedge clk); #1;
         checks++;
         if (res_valid !== 1'b1 || res_data !== exp_res) begin
            errors++;
            $display("FAIL result_hold: valid=%b data=%h, required 1 %h", res_valid, res_data, exp_res);
         end
      end
      res_ready = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (res_valid !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL result_exit: valid=%b busy=%b, required 0 0", res_valid, busy);
      end
      res_ready = 1'b0;
      checks++;
      if (cap_q.size() != exp_q.size()) begin
         errors++; $display("FAIL pe_beat_count: %0d, required %0d", cap_q.size(), exp_q.size());
      end else begin
         int bad = -1;
         for (int i = 0; i < exp_q.size(); i++) if (bad < 0 && cap_q[i] !== exp_q[i]) bad = i;
         if (bad >= 0) begin
            errors++;
            $display("FAIL pe_beats: beat %0d = %h, required %h", bad, cap_q[bad], exp_q[bad]);
         end
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      logic [21:0] v;
      v = {busy, s_ready, pe_en_in, pe_in_row, pe_en_out, res_valid, pe_in_data, res_data};
      checks++;
      if (v !== '0) begin
         errors++; $display("FAIL %s: outputs=%h, required 0", tag, v);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (pe_rstn !== 1'b0) begin
         errors++; $display("FAIL reset_pe_rstn: %b, required 0", pe_rstn);
      end
      check_idle_outputs("reset_state");
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      row_a = '{8'sh10, 8'sh00, 8'sh00};
      n_cols = 4;
      for (int i = 0; i < 4; i++) col_a[i] = 8'sh08;
      do_job(0, 0, 1'b1, 1'b0);
   endtask

   task automatic test_signed();
      row_a = '{-8'sh10, byte'($urandom), byte'($urandom)};
      n_cols = 2;
      col_a[0] = 8'sh08; col_a[1] = 8'sh04;
      do_job(0, 1, 1'b1, 1'b0);
   endtask

   task automatic test_stalls();
      row_a = '{8'sh10, 8'sh00, 8'sh00};
      n_cols = 4;
      for (int i = 0; i < 4; i++) col_a[i] = 8'sh08;
      do_job(1, 0, 1'b0, 1'b0);
   endtask

   task automatic test_zero_len();
      row_a = '{byte'($urandom), byte'($urandom), byte'($urandom)};
      n_cols = 0;
      do_job(0, 0, 1'b1, 1'b1);
   endtask

   task automatic test_backpressure();
      row_a = '{byte'($urandom), byte'($urandom), byte'($urandom)};
      n_cols = 5;
      for (int i = 0; i < 5; i++) col_a[i] = byte'($urandom);
      do_job(2, 5, 1'b0, 1'b1);
   endtask

   task automatic test_reset_midjob();
      row_a = '{byte'($urandom), byte'($urandom), byte'($urandom)};
      start = 1'b1; col_len = CW'(8);
      @(posedge clk); #1;
      start = 1'b0;
      s_valid = 1'b1;
      repeat (7) begin s_data = 8'($urandom); @(posedge clk); #1; end
      rst = 1'b1; #1;
      checks++;
      if (pe_rstn !== 1'b0) begin
         errors++; $display("FAIL midjob_pe_rstn: %b, required 0", pe_rstn);
      end
      repeat (3) begin
         @(posedge clk); #1;
         checks++;
         if (pe_rstn !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL midjob_in_reset: pe_rstn=%b busy=%b, required 0 0", pe_rstn, busy);
         end
      end
      s_valid = 1'b0;
      check_idle_outputs("midjob_reset_state");
      rst = 1'b0; res_ready = 1'b1;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk); #1;
         checks++;
         if (res_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL midjob_partial: valid=%b busy=%b, required 0 0", res_valid, busy);
         end
      end
      res_ready = 1'b0;
   endtask

   task automatic test_random();
      for (int j = 0; j < 8; j++) begin
         row_a = '{byte'($urandom), byte'($urandom), byte'($urandom)};
         n_cols = $urandom_range(0, 15);
         for (int i = 0; i < 16; i++) col_a[i] = byte'($urandom);
         do_job(2, $urandom_range(0, 3), 1'b0, 1'b0);
      end
   endtask

   task automatic test_back_to_back();
      for (int j = 0; j < 3; j++) begin
         row_a = '{byte'($urandom), byte'($urandom), byte'($urandom)};
         n_cols = $urandom_range(1, 15);
         for (int i = 0; i < 16; i++) col_a[i] = byte'($urandom);
         do_job(0, 0, 1'b1, 1'b0);
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; col_len = '0; s_data = '0; s_valid = 1'b0; res_ready = 1'b0;
      test_reset();
      test_basic();
      test_signed();
      test_stalls();
      test_zero_len();
      test_backpressure();
      test_reset_midjob();
      test_random();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
